// File: rtl/triple_buffer_ctrl.sv
// Triple-buffer frame sequencer: rotates one-hot frame ownership between the writer,
// the reader and the latest-complete slot, and generates the buffer addresses and strobes.
//
// state  | meaning
// R_IDLE | reader owns a stale frame, waits for r_req with a fresh frame available
// R_READ | reader is walking raddr through its granted frame
module triple_buffer_ctrl #(
    parameter int MAX_TAP = 448,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             w_valid,
    input  logic             r_req,
    input  logic             r_en,
    output logic [2:0]       w_buffer_id,
    output logic [2:0]       r_buffer_id,
    output logic [8:0]       waddr,
    output logic [8:0]       raddr,
    output logic             w_occur,
    output logic             r_occur,
    output logic             r_busy,
    output logic             r_done,
    output logic             frame_fresh,
    output logic [CNT_W-1:0] dropped_frames
);

    localparam logic [8:0] LAST_ADDR = 9'(MAX_TAP - 1);

    typedef enum logic {R_IDLE, R_READ} rd_state_t;

    rd_state_t  rd_state;
    logic [2:0] l_buffer_id;
    logic       w_last;
    logic       grant;
    logic       r_last;

    assign w_last  = w_valid && (waddr == LAST_ADDR);
    assign grant   = (rd_state == R_IDLE) && r_req && frame_fresh;
    assign r_last  = (rd_state == R_READ) && r_en && (raddr == LAST_ADDR);
    assign w_occur = w_valid;
    assign r_occur = r_en & r_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_buffer_id    <= 3'b001;
            r_buffer_id    <= 3'b010;
            l_buffer_id    <= 3'b100;
            waddr          <= '0;
            raddr          <= '0;
            frame_fresh    <= 1'b0;
            dropped_frames <= '0;
            rd_state       <= R_IDLE;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_done <= r_last;

            if (w_valid)
                waddr <= w_last ? '0 : waddr + 9'd1;

            // A completing write and a grant in the same cycle rotate all three frames.
            if (w_last && grant) begin
                w_buffer_id <= r_buffer_id;
                r_buffer_id <= l_buffer_id;
                l_buffer_id <= w_buffer_id;
            end else if (w_last) begin
                w_buffer_id <= l_buffer_id;
                l_buffer_id <= w_buffer_id;
            end else if (grant) begin
                r_buffer_id <= l_buffer_id;
                l_buffer_id <= r_buffer_id;
            end

            if (w_last)
                frame_fresh <= 1'b1;
            else if (grant)
                frame_fresh <= 1'b0;

            // Only an unread L that gets replaced counts as a drop.
            if (w_last && !grant && frame_fresh && (dropped_frames != '1))
                dropped_frames <= dropped_frames + CNT_W'(1);

            case (rd_state)
                R_IDLE: begin
                    if (grant) begin
                        rd_state <= R_READ;
                        r_busy   <= 1'b1;
                        raddr    <= '0;
                    end
                end
                R_READ: begin
                    if (r_en) begin
                        if (raddr == LAST_ADDR) begin
                            raddr    <= '0;
                            rd_state <= R_IDLE;
                            r_busy   <= 1'b0;
                        end else begin
                            raddr <= raddr + 9'd1;
                        end
                    end
                end
                default: begin
                    rd_state <= R_IDLE;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule
